washing_machine_prog: RTL and testbench
=======================================

Name: washing_machine_prog

Overview:
Programmable washing-machine sequencer, successor to the fixed sensor-driven washing FSM. Adds timed wash/rinse/spin phases, a configurable number of rinse cycles and optional heating. Adds sensor-wait timeouts with error reporting, user abort with safe drain, and a done pulse. Sits between the user panel/config registers and the actuator drivers.

Parameters:
TIMER_W, 16, width of wash_time/spin_time and internal phase timer
TICK_DIV, 50000, clk50m cycles per timer tick (1 ms); 1 = tick every cycle (sim)
TIMEOUT_TICKS, 60000, max ticks to wait for a sensor in FILL/HEAT/DRAIN/ABORT
RINSE_TICKS, 30000, duration of each RINSE phase in ticks

Ports:
clk50m  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
start  in  1  start request, sampled in IDLE only
abort  in  1  user abort request
clear_err  in  1  acknowledge error, leave ERROR
door_closed  in  1  door sensor
full  in  1  water level reached
hot  in  1  water temperature reached
wash_time  in  TIMER_W  wash duration, ticks
spin_time  in  TIMER_W  spin duration, ticks
rinse_cnt  in  3  number of rinse cycles, 0..7
skip_heat  in  1  1 = bypass HEAT
door_lock, valve, heater, motor_wash, motor_spin, pump  out  1 each  actuators
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal completion
error  out  1  state == ERROR
err_code  out  2  0 none, 1 fill timeout, 2 heat timeout, 3 drain timeout
state_o  out  4  current state encoding

Behaviour:
- Reset: clk50m and rst_n are decided as stated above. On reset, state=IDLE; prescaler, timer, rinse counter and err_code cleared; all outputs 0 immediately (asynchronous), including door_lock.
- Moore outputs, decoded from the state register. State encodings: IDLE=0, FILL=1, HEAT=2, WASH=3, DRAIN=4, RINSE=5, SPIN=6, DONE=7, ABORT=8, ERROR=9.
- Actuator outputs per state (all others 0):
  - FILL: valve, door_lock.
  - HEAT: heater, door_lock.
  - WASH and RINSE: motor_wash, door_lock.
  - DRAIN and ABORT: pump, door_lock.
  - SPIN: motor_spin, pump, door_lock.
  - DONE: door_lock.
  - ERROR: pump=1, door_lock=full.
- IDLE: start=1 and door_closed=1 → FILL. On that same edge:
  - latch wash_time, spin_time, rinse_cnt, skip_heat into config registers;
  - clear err_code;
  - clear the rinse-phase flag.
  - start with door_closed=0 is ignored.
  - Input changes after acceptance have no effect.
- FILL: full=1 → RINSE if rinse-phase flag set; else WASH if skip_heat; else HEAT.
- HEAT: hot=1 → WASH.
- WASH: timed by wash_time → DRAIN.
- RINSE: timed by RINSE_TICKS → DRAIN.
- DRAIN: full=0 → FILL if rinse_left>0 (decrement rinse_left, set rinse-phase flag); else SPIN.
- SPIN: timed by spin_time → DONE.
- DONE: one cycle, done=1 → IDLE.
- Timing:
  - The free-running prescaler emits a 1-cycle tick every TICK_DIV cycles.
  - Timed phase: counter loaded with N on state entry. On each tick: exit if count ≤ 1, else decrement.
  - With TICK_DIV=1, a timed state lasts exactly max(N,1) cycles. With TICK_DIV>1, ±1 tick accuracy is acceptable.
- Timeouts:
  - A wait counter is cleared on entry to FILL/HEAT/DRAIN/ABORT and increments per tick.
  - Reaching TIMEOUT_TICKS without the exit condition → ERROR, err_code = 1 (FILL), 2 (HEAT), 3 (DRAIN or ABORT).
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- Abort:
  - abort=1 in any state other than IDLE, ABORT or ERROR → ABORT on the next edge.
  - Abort has priority over timeout and normal transitions in the same cycle.
  - ABORT: full=0 → IDLE. done is not pulsed and err_code is unchanged.
- ERROR: clear_err=1 and full=0 → IDLE. err_code holds until the next accepted start.
- Unused encodings → ABORT on the next edge.

Test Plan (TICK_DIV=1, TIMEOUT_TICKS=20, RINSE_TICKS=4):
1. Normal cycle:
   - Stimulus: door_closed=1, start pulse, wash_time=5, spin_time=3, rinse_cnt=1, skip_heat=0; full rises 2 cycles into FILL; hot rises 3 cycles into HEAT; full falls 2 cycles into each DRAIN; full re-rises in the second FILL.
   - Required: state sequence 1,2,3(5 cycles),4,1,5(4 cycles),4,6(3 cycles),7,0; heater never on in the second FILL; done high exactly 1 cycle.
2. skip_heat=1, rinse_cnt=0, wash_time=0 → FILL→WASH (1 cycle)→DRAIN→SPIN; heater never asserted.
3. Fill timeout:
   - Stimulus: full held 0.
   - Required: ERROR after 20 cycles in FILL, err_code=1, pump=1, valve=0.
   - Then: clear_err=1 → IDLE; err_code stays 1 until the next accepted start clears it.
4. Abort during WASH with full=1 → ABORT next cycle (motor_wash=0, pump=1, door_lock=1); full=0 → IDLE; done never pulses.
5. Start with door_closed=0 → remains IDLE, busy=0. Start accepted, then wash_time changed mid-run → WASH duration equals the latched value.
6. Reset asserted mid-HEAT → all outputs 0 without a clock edge; state_o=0; after release, start required to restart.

Source files
------------

// File: rtl/washing_machine_prog_if.sv
// Panel/config and actuator signal bundle for the programmable washing-machine sequencer.
// master = panel/driver side, slave = sequencer.
interface washing_machine_prog_if #(
   parameter int TIMER_W = 16
);
   logic               start;
   logic               abort;
   logic               clear_err;
   logic               door_closed;
   logic               full;
   logic               hot;
   logic [TIMER_W-1:0] wash_time;
   logic [TIMER_W-1:0] spin_time;
   logic [2:0]         rinse_cnt;
   logic               skip_heat;
   logic               door_lock;
   logic               valve;
   logic               heater;
   logic               motor_wash;
   logic               motor_spin;
   logic               pump;
   logic               busy;
   logic               done;
   logic               error;
   logic [1:0]         err_code;
   logic [3:0]         state_o;

   modport master (
      output start, abort, clear_err, door_closed, full, hot,
             wash_time, spin_time, rinse_cnt, skip_heat,
      input  door_lock, valve, heater, motor_wash, motor_spin, pump,
             busy, done, error, err_code, state_o
   );

   modport slave (
      input  start, abort, clear_err, door_closed, full, hot,
             wash_time, spin_time, rinse_cnt, skip_heat,
      output door_lock, valve, heater, motor_wash, motor_spin, pump,
             busy, done, error, err_code, state_o
   );
endinterface

// File: rtl/washing_machine_prog.sv
// Programmable washing-machine sequencer: timed wash/rinse/spin, optional heat,
// sensor-wait timeouts with error codes, user abort with safe drain.
module washing_machine_prog #(
   parameter int TIMER_W       = 16,
   parameter int TICK_DIV      = 50000,
   parameter int TIMEOUT_TICKS = 60000,
   parameter int RINSE_TICKS   = 30000
) (
   input logic                  clk50m,
   input logic                  rst_n,
   washing_machine_prog_if.slave wm
);
   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_FILL  = 4'd1;
   localparam logic [3:0] S_HEAT  = 4'd2;
   localparam logic [3:0] S_WASH  = 4'd3;
   localparam logic [3:0] S_DRAIN = 4'd4;
   localparam logic [3:0] S_RINSE = 4'd5;
   localparam logic [3:0] S_SPIN  = 4'd6;
   localparam logic [3:0] S_DONE  = 4'd7;
   localparam logic [3:0] S_ABORT = 4'd8;
   localparam logic [3:0] S_ERROR = 4'd9;

   localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int WAIT_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT_TICKS - 1);
   localparam logic [TIMER_W-1:0] RINSE_LOAD = TIMER_W'(RINSE_TICKS);

   logic [3:0]         state_reg, state_next;
   logic [1:0]         err_reg, err_next;
   logic [PRE_W-1:0]   pre_reg;
   logic [TIMER_W-1:0] timer_reg, timer_load;
   logic [WAIT_W-1:0]  wait_reg;
   logic [TIMER_W-1:0] wash_cfg_reg, spin_cfg_reg;
   logic               skip_cfg_reg;
   logic [2:0]         rinse_left_reg;
   logic               rinse_phase_reg;
   logic               tick, timer_done, wait_expired, entry, accept, rinse_step;

   assign tick         = (pre_reg == PRE_LAST);
   assign timer_done   = tick && (timer_reg <= TIMER_W'(1));
   assign wait_expired = tick && (wait_reg == WAIT_LAST);
   assign entry        = (state_next != state_reg);
   assign accept       = (state_reg == S_IDLE) && (state_next == S_FILL);
   assign rinse_step   = (state_reg == S_DRAIN) && (state_next == S_FILL);

   always_comb begin
      state_next = state_reg;
      err_next   = err_reg;
      case (state_reg)
         S_IDLE:  if (wm.start && wm.door_closed) begin
                     state_next = S_FILL;
                     err_next   = 2'd0;
                  end
         S_FILL:  if (wm.full)
                     state_next = rinse_phase_reg ? S_RINSE : (skip_cfg_reg ? S_WASH : S_HEAT);
                  else if (wait_expired) begin
                     state_next = S_ERROR;
                     err_next   = 2'd1;
                  end
         S_HEAT:  if (wm.hot)
                     state_next = S_WASH;
                  else if (wait_expired) begin
                     state_next = S_ERROR;
                     err_next   = 2'd2;
                  end
         S_WASH:  if (timer_done) state_next = S_DRAIN;
         S_DRAIN: if (!wm.full)
                     state_next = (rinse_left_reg != 3'd0) ? S_FILL : S_SPIN;
                  else if (wait_expired) begin
                     state_next = S_ERROR;
                     err_next   = 2'd3;
                  end
         S_RINSE: if (timer_done) state_next = S_DRAIN;
         S_SPIN:  if (timer_done) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         S_ABORT: if (!wm.full)
                     state_next = S_IDLE;
                  else if (wait_expired) begin
                     state_next = S_ERROR;
                     err_next   = 2'd3;
                  end
         S_ERROR: if (wm.clear_err && !wm.full) state_next = S_IDLE;
         default: state_next = S_ABORT;
      endcase
      // Abort overrides every same-cycle transition, including timeouts
      if (wm.abort && state_reg != S_IDLE && state_reg != S_ABORT && state_reg != S_ERROR) begin
         state_next = S_ABORT;
         err_next   = err_reg;
      end
   end

   always_comb begin
      case (state_next)
         S_WASH:  timer_load = wash_cfg_reg;
         S_RINSE: timer_load = RINSE_LOAD;
         S_SPIN:  timer_load = spin_cfg_reg;
         default: timer_load = '0;
      endcase
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         err_reg         <= 2'd0;
         pre_reg         <= '0;
         timer_reg       <= '0;
         wait_reg        <= '0;
         wash_cfg_reg    <= '0;
         spin_cfg_reg    <= '0;
         skip_cfg_reg    <= 1'b0;
         rinse_left_reg  <= 3'd0;
         rinse_phase_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= err_next;
         pre_reg   <= tick ? '0 : pre_reg + PRE_W'(1);
         if (accept) begin
            wash_cfg_reg    <= wm.wash_time;
            spin_cfg_reg    <= wm.spin_time;
            skip_cfg_reg    <= wm.skip_heat;
            rinse_left_reg  <= wm.rinse_cnt;
            rinse_phase_reg <= 1'b0;
         end else if (rinse_step) begin
            rinse_left_reg  <= rinse_left_reg - 3'd1;
            rinse_phase_reg <= 1'b1;
         end
         // Timer and wait counter restart on every state entry
         if (entry) begin
            wait_reg  <= '0;
            timer_reg <= timer_load;
         end else begin
            if (tick && wait_reg != WAIT_LAST)
               wait_reg <= wait_reg + WAIT_W'(1);
            if (tick && timer_reg > TIMER_W'(1))
               timer_reg <= timer_reg - TIMER_W'(1);
         end
      end
   end

   always_comb begin
      wm.door_lock  = 1'b0;
      wm.valve      = 1'b0;
      wm.heater     = 1'b0;
      wm.motor_wash = 1'b0;
      wm.motor_spin = 1'b0;
      wm.pump       = 1'b0;
      case (state_reg)
         S_FILL:  begin wm.valve = 1'b1;      wm.door_lock = 1'b1; end
         S_HEAT:  begin wm.heater = 1'b1;     wm.door_lock = 1'b1; end
         S_WASH,
         S_RINSE: begin wm.motor_wash = 1'b1; wm.door_lock = 1'b1; end
         S_DRAIN,
         S_ABORT: begin wm.pump = 1'b1;       wm.door_lock = 1'b1; end
         S_SPIN:  begin wm.motor_spin = 1'b1; wm.pump = 1'b1; wm.door_lock = 1'b1; end
         S_DONE:  wm.door_lock = 1'b1;
         S_ERROR: begin wm.pump = 1'b1;       wm.door_lock = wm.full; end
         default: ;
      endcase
      wm.busy     = (state_reg != S_IDLE);
      wm.done     = (state_reg == S_DONE);
      wm.error    = (state_reg == S_ERROR);
      wm.err_code = err_reg;
      wm.state_o  = state_reg;
   end
endmodule

// File: tb/tb_washing_machine_prog.sv
// Bench for washing_machine_prog: phase-level reference model with per-cycle compare,
// a simple water/heat plant, directed scenarios and randomized programs.
module tb_washing_machine_prog;
   localparam int TW = 16;
   localparam int TO = 20;
   localparam int RT = 4;
   localparam int S_IDLE = 0, S_FILL = 1, S_HEAT = 2, S_WASH = 3, S_DRAIN = 4;
   localparam int S_RINSE = 5, S_SPIN = 6, S_DONE = 7, S_ABORT = 8, S_ERROR = 9;

   logic clk50m = 1'b0;
   logic rst_n  = 1'b0;

   washing_machine_prog_if #(.TIMER_W(TW)) wm_if ();

   washing_machine_prog #(
      .TIMER_W(TW), .TICK_DIV(1), .TIMEOUT_TICKS(TO), .RINSE_TICKS(RT)
   ) dut (
      .clk50m(clk50m),
      .rst_n (rst_n),
      .wm    (wm_if)
   );

   always #10 clk50m = ~clk50m;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: current phase plus cycles already spent in it
   int m_st = 0, m_el = 0, m_err = 0, m_wash = 0, m_spin = 0, m_rleft = 0, m_rph = 0, m_skip = 0;

   initial begin
      int nst, el;
      forever begin
         @(posedge clk50m or negedge rst_n);
         if (!rst_n) begin
            m_st = S_IDLE; m_el = 0; m_err = 0; m_rleft = 0; m_rph = 0;
         end else begin
            nst = m_st;
            el  = m_el + 1;
            if (wm_if.abort && m_st != S_IDLE && m_st != S_ABORT && m_st != S_ERROR)
               nst = S_ABORT;
            else case (m_st)
               S_IDLE:  if (wm_if.start && wm_if.door_closed) begin
                           nst = S_FILL; m_err = 0; m_rph = 0;
                           m_rleft = int'(wm_if.rinse_cnt);
                           m_wash = int'(wm_if.wash_time); m_spin = int'(wm_if.spin_time);
                           m_skip = int'(wm_if.skip_heat);
                        end
               S_FILL:  if (wm_if.full) nst = m_rph ? S_RINSE : (m_skip ? S_WASH : S_HEAT);
                        else if (el >= TO) begin nst = S_ERROR; m_err = 1; end
               S_HEAT:  if (wm_if.hot) nst = S_WASH;
                        else if (el >= TO) begin nst = S_ERROR; m_err = 2; end
               S_WASH:  if (el >= ((m_wash < 1) ? 1 : m_wash)) nst = S_DRAIN;
               S_RINSE: if (el >= RT) nst = S_DRAIN;
               S_DRAIN: if (!wm_if.full) begin
                           if (m_rleft > 0) begin nst = S_FILL; m_rleft--; m_rph = 1; end
                           else nst = S_SPIN;
                        end else if (el >= TO) begin nst = S_ERROR; m_err = 3; end
               S_SPIN:  if (el >= ((m_spin < 1) ? 1 : m_spin)) nst = S_DONE;
               S_DONE:  nst = S_IDLE;
               S_ABORT: if (!wm_if.full) nst = S_IDLE;
                        else if (el >= TO) begin nst = S_ERROR; m_err = 3; end
               S_ERROR: if (wm_if.clear_err && !wm_if.full) nst = S_IDLE;
               default: nst = S_ABORT;
            endcase
            m_el = (nst != m_st) ? 0 : el;
            m_st = nst;
         end
      end
   end

   function automatic logic [14:0] exp_vec(int st, int err, logic full);
      logic dl, va, he, mw, ms, pu;
      {dl, va, he, mw, ms, pu} = 6'b0;
      case (st)
         S_FILL:          begin va = 1; dl = 1; end
         S_HEAT:          begin he = 1; dl = 1; end
         S_WASH, S_RINSE: begin mw = 1; dl = 1; end
         S_DRAIN, S_ABORT:begin pu = 1; dl = 1; end
         S_SPIN:          begin ms = 1; pu = 1; dl = 1; end
         S_DONE:          dl = 1;
         S_ERROR:         begin pu = 1; dl = full; end
         default: ;
      endcase
      return {4'(st), dl, va, he, mw, ms, pu, st != 0, st == S_DONE, st == S_ERROR, 2'(err)};
   endfunction

   function automatic logic [14:0] dut_vec();
      return {wm_if.state_o, wm_if.door_lock, wm_if.valve, wm_if.heater, wm_if.motor_wash,
              wm_if.motor_spin, wm_if.pump, wm_if.busy, wm_if.done, wm_if.error, wm_if.err_code};
   endfunction

   // Per-cycle compare plus run-length log of observed states
   int runs_s[$], runs_l[$];
   int cur_s = 0, cur_len = 0, done_cnt = 0;
   initial begin
      logic [14:0] e, a;
      forever begin
         @(negedge clk50m);
         e = exp_vec(m_st, m_err, wm_if.full);
         a = dut_vec();
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t actual=%b required=%b", $time, a, e);
         end
         if (int'(wm_if.state_o) == cur_s) cur_len++;
         else begin
            runs_s.push_back(cur_s); runs_l.push_back(cur_len);
            cur_s = int'(wm_if.state_o); cur_len = 1;
         end
         if (wm_if.done) done_cnt++;
      end
   end

   // Plant: water level and temperature respond after programmable delays
   int fill_delay = 2, heat_delay = 3, drain_delay = 2;
   initial begin
      int s, ps, pc;
      ps = -1; pc = 0;
      forever begin
         @(posedge clk50m); #2;
         s = int'(wm_if.state_o);
         if (s == ps) pc++; else pc = 0;
         ps = s;
         case (s)
            S_FILL:           if (pc >= fill_delay) wm_if.full = 1'b1;
            S_HEAT:           if (pc >= heat_delay) wm_if.hot = 1'b1;
            S_DRAIN, S_ABORT: if (pc >= drain_delay) wm_if.full = 1'b0;
            S_ERROR:          if (pc >= 2) wm_if.full = 1'b0;
            default: ;
         endcase
         if (s != S_HEAT) wm_if.hot = 1'b0;
      end
   end

   task automatic tick_n(int n);
      repeat (n) begin @(posedge clk50m); #2; end
   endtask

   task automatic chk(string name, int act, int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic wait_state(int s, int budget, string name);
      int c = 0;
      while (int'(wm_if.state_o) != s && c < budget) begin tick_n(1); c++; end
      chk(name, int'(wm_if.state_o), s);
   endtask

   task automatic do_start(int wt, int st, int rc, int sk);
      wm_if.wash_time = TW'(wt); wm_if.spin_time = TW'(st);
      wm_if.rinse_cnt = 3'(rc);  wm_if.skip_heat = sk[0];
      wm_if.door_closed = 1'b1;  wm_if.start = 1'b1;
      tick_n(1);
      wm_if.start = 1'b0;
   endtask

   task automatic clear_runs();
      runs_s.delete(); runs_l.delete(); done_cnt = 0;
   endtask

   int exp_s[$], exp_l[$];
   task automatic check_seq(string name);
      chk({name, "_len"}, runs_s.size(), exp_s.size() + 1);
      if (runs_s.size() == exp_s.size() + 1)
         foreach (exp_s[i]) begin
            chk({name, "_state"}, runs_s[i+1], exp_s[i]);
            if (exp_l[i] >= 0) chk({name, "_cycles"}, runs_l[i+1], exp_l[i]);
         end
   endtask

   initial begin
      int ab_at, c;
      wm_if.start = 0; wm_if.abort = 0; wm_if.clear_err = 0; wm_if.door_closed = 1;
      wm_if.full = 0; wm_if.hot = 0; wm_if.wash_time = '0; wm_if.spin_time = '0;
      wm_if.rinse_cnt = '0; wm_if.skip_heat = 0;
      tick_n(2);
      chk("reset_outputs", int'(dut_vec()), 0);
      rst_n = 1'b1;
      tick_n(3);

      // Normal cycle with heat and one rinse
      clear_runs();
      do_start(5, 3, 1, 0);
      wait_state(S_IDLE, 200, "t1_finish"); tick_n(1);
      exp_s = '{1, 2, 3, 4, 1, 5, 4, 6, 7}; exp_l = '{-1, -1, 5, -1, -1, 4, -1, 3, 1};
      check_seq("t1");
      chk("t1_done_pulses", done_cnt, 1);

      // Fill timeout, error hold, clear
      fill_delay = 1000;
      clear_runs();
      do_start(3, 2, 0, 0);
      wait_state(S_ERROR, 40, "t3_enter_error"); tick_n(1);
      chk("t3_err_code", int'(wm_if.err_code), 1);
      chk("t3_pump", int'(wm_if.pump), 1);
      chk("t3_valve", int'(wm_if.valve), 0);
      wm_if.clear_err = 1'b1;
      wait_state(S_IDLE, 10, "t3_leave_error");
      wm_if.clear_err = 1'b0;
      tick_n(2);
      chk("t3_err_hold_idle", int'(wm_if.err_code), 1);
      exp_s = '{1, 9}; exp_l = '{20, -1};
      check_seq("t3");

      // skip_heat, no rinse, zero wash time; start clears err_code
      fill_delay = 2;
      clear_runs();
      do_start(0, 2, 0, 1);
      chk("t2_err_cleared", int'(wm_if.err_code), 0);
      wait_state(S_IDLE, 200, "t2_finish"); tick_n(1);
      exp_s = '{1, 3, 4, 6, 7}; exp_l = '{-1, 1, -1, 2, 1};
      check_seq("t2");

      // Abort during WASH with tub full
      fill_delay = 1;
      clear_runs();
      do_start(10, 2, 0, 1);
      wait_state(S_WASH, 20, "t4_reach_wash");
      tick_n(2);
      wm_if.abort = 1'b1; tick_n(1); wm_if.abort = 1'b0;
      chk("t4_state_abort", int'(wm_if.state_o), S_ABORT);
      chk("t4_motor_wash", int'(wm_if.motor_wash), 0);
      chk("t4_pump", int'(wm_if.pump), 1);
      chk("t4_door_lock", int'(wm_if.door_lock), 1);
      wait_state(S_IDLE, 40, "t4_finish"); tick_n(1);
      chk("t4_no_done", done_cnt, 0);
      exp_s = '{1, 3, 8}; exp_l = '{-1, 3, -1};
      check_seq("t4");

      // Start with door open is ignored; config is latched at acceptance
      wm_if.door_closed = 1'b0; wm_if.start = 1'b1;
      tick_n(3);
      wm_if.start = 1'b0;
      chk("t5_door_open_state", int'(wm_if.state_o), S_IDLE);
      chk("t5_door_open_busy", int'(wm_if.busy), 0);
      clear_runs();
      do_start(5, 1, 0, 1);
      wm_if.wash_time = TW'(2); wm_if.skip_heat = 1'b0; wm_if.rinse_cnt = 3'd3;
      wait_state(S_IDLE, 200, "t5_finish"); tick_n(1);
      exp_s = '{1, 3, 4, 6, 7}; exp_l = '{-1, 5, -1, 1, 1};
      check_seq("t5");

      // Randomized programs, sensor delays straddling the timeout, random aborts
      for (int it = 0; it < 40; it++) begin
         fill_delay  = $urandom_range(0, 22);
         heat_delay  = $urandom_range(0, 22);
         drain_delay = $urandom_range(0, 22);
         wm_if.wash_time = TW'($urandom_range(0, 6));
         wm_if.spin_time = TW'($urandom_range(0, 4));
         wm_if.rinse_cnt = 3'($urandom_range(0, 2));
         wm_if.skip_heat = 1'($urandom_range(0, 1));
         wm_if.door_closed = ($urandom_range(0, 4) != 0);
         wm_if.start = 1'b1; tick_n(1); wm_if.start = 1'b0;
         wm_if.door_closed = 1'b1;
         ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
         c = 0;
         while (c < 600 && !(int'(wm_if.state_o) == S_IDLE && c > ab_at)) begin
            wm_if.abort = (c == ab_at);
            wm_if.clear_err = (int'(wm_if.state_o) == S_ERROR);
            tick_n(1);
            c++;
         end
         wm_if.abort = 1'b0; wm_if.clear_err = 1'b0;
         chk("rand_back_to_idle", int'(wm_if.state_o), S_IDLE);
         tick_n(1);
      end

      // Asynchronous reset in the middle of HEAT
      fill_delay = 2; heat_delay = 10; drain_delay = 2;
      do_start(4, 2, 0, 0);
      wait_state(S_HEAT, 40, "t6_reach_heat");
      tick_n(2);
      #5 rst_n = 1'b0;
      #1 chk("t6_async_outputs", int'(dut_vec()), 0);
      tick_n(2);
      rst_n = 1'b1;
      tick_n(3);
      chk("t6_idle_after_reset", int'(wm_if.state_o), S_IDLE);
      chk("t6_busy_after_reset", int'(wm_if.busy), 0);
      heat_delay = 3;
      clear_runs();
      do_start(2, 2, 0, 0);
      wait_state(S_IDLE, 200, "t6_restart_finish"); tick_n(1);
      chk("t6_restart_done", done_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
